mod_exp_engine: RTL



---
 rtl/rsa_pkg.sv | 19 +
 rtl/mod_exp_engine_if.sv | 19 +
 rtl/mod_mul.sv | 63 ++++++
 rtl/mod_exp_engine.sv | 131 +++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared constants and state encoding for the modular exponentiation datapath.
// Purely declarative: no logic, no latency.
// No backpressure; consumers are single-issue engines.
package rsa_pkg;

    localparam int WIDTH      = 32;
    localparam int MUL_CYCLES = 32;
    localparam int CNT_W      = $clog2(MUL_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_MUL_GO,
        ST_MUL_RUN,
        ST_UPDATE,
        ST_FINISH
    } exp_state_t;

endpackage

// File: rtl/mod_exp_engine_if.sv
// Request/response bundle between key management and the mod-exp engine.
// Latency: n/a (wires only).
// Backpressure: requester must only raise start while busy is low; otherwise it is ignored.
interface mod_exp_engine_if import rsa_pkg::*; #(parameter int W = WIDTH);
    logic         start;
    logic         abort;
    logic [W-1:0] base;
    logic [W-1:0] exponent;
    logic [W-1:0] modulus;
    logic         busy;
    logic         done;
    logic         error;
    logic [W-1:0] result;

    modport master (output start, abort, base, exponent, modulus,
                    input  busy, done, error, result);
    modport slave  (input  start, abort, base, exponent, modulus,
                    output busy, done, error, result);
endinterface

// File: rtl/mod_mul.sv
// Bit-serial interleaved modular multiplier: p = a*b mod n, multiplier bits MSB first.
// Latency: W cycles from start to the one-cycle valid pulse.
// No backpressure; a start while busy restarts the operation. Requires a,b < n.
module mod_mul import rsa_pkg::*; #(parameter int W = WIDTH) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] n_i,
    output logic         busy_o,
    output logic         valid_o,
    output logic [W-1:0] p_o
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  a_q, b_q, n_q, acc_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q, valid_q;
    logic [W+1:0]  t0, t1, nx;
    logic [W-1:0]  t2;

    // One shift-add step followed by two conditional subtracts; acc < n keeps t < 3n.
    always_comb begin
        nx = {2'b00, n_q};
        t0 = {1'b0, acc_q, 1'b0} + {2'b00, (b_q & {W{a_q[W-1]}})};
        t1 = (t0 >= nx) ? (t0 - nx) : t0;
        t2 = (t1 >= nx) ? W'(t1 - nx) : W'(t1);
    end

    // Operand capture on start, then one multiplier bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            n_q     <= n_i;
            acc_q   <= '0;
            cnt_q   <= CW'(W);
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
        end else if (busy_q) begin
            acc_q   <= t2;
            a_q     <= a_q << 1;
            cnt_q   <= cnt_q - CW'(1);
            busy_q  <= (cnt_q != CW'(1));
            valid_q <= (cnt_q == CW'(1));
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign busy_o  = busy_q;
    assign valid_o = valid_q;
    assign p_o     = acc_q;
endmodule

// File: rtl/mod_exp_engine.sv
// Right-to-left square-and-multiply modular exponentiation, constant 34 cycles per exponent bit.
// Latency: 2 + 34*(k+1) cycles, k = index of highest set exponent bit; 2 cycles on error or exponent 0.
// Backpressure: start ignored while busy; abort cancels immediately without a done pulse.
module mod_exp_engine import rsa_pkg::*; (
    input  logic            clk,
    input  logic            rst_n,
    mod_exp_engine_if.slave bus
);
    exp_state_t       state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d, r_q, r_d, e_q, e_d, n_q, n_d, res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d, errp_q, errp_d;
    logic             mul_go;
    logic [WIDTH-1:0] pa, ps;
    logic             pa_busy, ps_busy, pa_vld, ps_vld;

    // Mult A: R*S (multiply step); Mult S: S*S (square step); both see the pre-update S.
    mod_mul #(.W(WIDTH)) u_mul_a (.clk(clk), .rst_n(rst_n), .start_i(mul_go),
        .a_i(r_q), .b_i(s_q), .n_i(n_q), .busy_o(pa_busy), .valid_o(pa_vld), .p_o(pa));
    mod_mul #(.W(WIDTH)) u_mul_s (.clk(clk), .rst_n(rst_n), .start_i(mul_go),
        .a_i(s_q), .b_i(s_q), .n_i(n_q), .busy_o(ps_busy), .valid_o(ps_vld), .p_o(ps));

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            r_q     <= '0;
            e_q     <= '0;
            n_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            errp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            r_q     <= r_d;
            e_q     <= e_d;
            n_q     <= n_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            errp_q  <= errp_d;
        end
    end

    // Next-state and datapath updates; abort overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        r_d     = r_q;
        e_d     = e_q;
        n_d     = n_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        errp_d  = errp_q;
        mul_go  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    s_d     = bus.base;
                    e_d     = bus.exponent;
                    n_d     = bus.modulus;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    errp_d  = 1'b0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if ((n_q < WIDTH'(2)) || (s_q >= n_q)) begin
                    errp_d  = 1'b1;
                    r_d     = '0;
                    state_d = ST_FINISH;
                end else begin
                    r_d     = WIDTH'(1);
                    state_d = (e_q == '0) ? ST_FINISH : ST_MUL_GO;
                end
            end
            ST_MUL_GO: begin
                mul_go  = 1'b1;
                cnt_d   = '0;
                state_d = ST_MUL_RUN;
            end
            ST_MUL_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Fixed cycle count; a stopped multiplier pair also ends the wait defensively.
                if ((cnt_q == CNT_W'(MUL_CYCLES - 1)) || !(pa_busy || ps_busy))
                    state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                if (pa_vld && ps_vld) begin
                    if (e_q[0])
                        r_d = pa;
                    s_d = ps;
                end
                e_d     = e_q >> 1;
                state_d = (e_q[WIDTH-1:1] == '0) ? ST_FINISH : ST_MUL_GO;
            end
            ST_FINISH: begin
                res_d   = errp_q ? '0 : r_q;
                err_d   = errp_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            res_d   = res_q;
            err_d   = err_q;
            mul_go  = 1'b0;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.error  = err_q;
    assign bus.result = res_q;
endmodule
